// File: rtl/fpu_host_if.sv
// Host-bus front end for the FPU core: operand staging, command FIFO,
// single-issue dispatch FSM, and a result FIFO drained via cmd_end/end_ack.
module fpu_host_if #(
   parameter int DATA_W    = 8,
   parameter int OP_W      = 32,
   parameter int OPC_W     = 4,
   parameter int CMD_DEPTH = 4,
   parameter int RES_DEPTH = 4
) (
   input  logic              clk,
   input  logic              arst_n,
   input  logic [DATA_W-1:0] databus_in,
   output logic [DATA_W-1:0] databus_out,
   input  logic [4:0]        addr,
   input  logic              cs,
   input  logic              rd,
   input  logic              wr,
   input  logic              end_ack,
   output logic              cmd_end,
   output logic              busy,
   output logic [OP_W-1:0]   core_a,
   output logic [OP_W-1:0]   core_b,
   output logic [OPC_W-1:0]  core_op,
   output logic              core_start,
   input  logic              core_done,
   input  logic [OP_W-1:0]   core_result
);

   localparam int LANES = OP_W / DATA_W;
   localparam int CAW   = $clog2(CMD_DEPTH);
   localparam int RAW   = $clog2(RES_DEPTH);
   localparam int CCW   = CAW + 1;
   localparam int RCW   = RAW + 1;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

   state_t            state_q, state_d;
   logic              wr_q, end_ack_q;
   logic              ovf_q, ovf_d;
   logic              discard_q, discard_d;
   logic [OP_W-1:0]   a_q, a_d, b_q, b_d;
   logic [OP_W-1:0]   core_a_q, core_b_q;
   logic [OPC_W-1:0]  core_op_q;

   logic [OP_W-1:0]   cmd_a_mem  [CMD_DEPTH];
   logic [OP_W-1:0]   cmd_b_mem  [CMD_DEPTH];
   logic [OPC_W-1:0]  cmd_op_mem [CMD_DEPTH];
   logic [CAW-1:0]    cmd_wp_q, cmd_rp_q;
   logic [CCW-1:0]    cmd_cnt_q, cmd_cnt_d;

   logic [OP_W-1:0]   res_mem [RES_DEPTH];
   logic [RAW-1:0]    res_wp_q, res_rp_q;
   logic [RCW-1:0]    res_cnt_q, res_cnt_d;

   logic              wr_ev, push_req, ctl_wr, flush, ovf_clr;
   logic [1:0]        lane;
   logic              lane_ok;
   logic              cmd_full, cmd_empty, cmd_push, cmd_pop;
   logic              res_full, res_empty, res_push, res_pop;
   logic              load_core;
   logic [OP_W-1:0]   res_head;
   logic [2:0]        res_sat;
   logic [7:0]        status;
   logic [DATA_W-1:0] rdata;

   // Host write decode: one event per falling edge of wr while selected
   assign wr_ev    = !cs && !wr && wr_q;
   assign lane     = addr[1:0];
   assign lane_ok  = 32'(lane) < LANES;
   assign push_req = wr_ev && (addr == 5'h08);
   assign ctl_wr   = wr_ev && (addr == 5'h09);
   assign flush    = ctl_wr && databus_in[0];
   assign ovf_clr  = ctl_wr && databus_in[1];

   assign cmd_full  = cmd_cnt_q == CCW'(CMD_DEPTH);
   assign cmd_empty = cmd_cnt_q == '0;
   assign cmd_pop   = (state_q == S_ISSUE) && !flush;
   assign cmd_push  = push_req && (!cmd_full || cmd_pop);

   assign res_full  = res_cnt_q == RCW'(RES_DEPTH);
   assign res_empty = res_cnt_q == '0;
   assign res_push  = (state_q == S_WAIT) && core_done && !discard_q && !flush;
   assign res_pop   = end_ack && !end_ack_q && !res_empty && !flush;
   assign res_head  = res_mem[res_rp_q];

   assign load_core = (state_q == S_IDLE) && (state_d == S_ISSUE);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (!cmd_empty && !discard_q && !res_full) state_d = S_ISSUE;
         S_ISSUE: state_d = S_WAIT;
         S_WAIT:  if (core_done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   // A flush that abandons an issued operation must swallow its late result
   always_comb begin
      discard_d = discard_q;
      if (core_done) discard_d = 1'b0;
      if (flush && ((state_q == S_ISSUE) || ((state_q == S_WAIT) && !core_done)))
         discard_d = 1'b1;
   end

   always_comb begin
      ovf_d = ovf_q;
      if (ovf_clr) ovf_d = 1'b0;
      if (push_req && cmd_full && !cmd_pop) ovf_d = 1'b1;
   end

   always_comb begin
      a_d = a_q;
      b_d = b_q;
      if (wr_ev && lane_ok) begin
         if (addr[4:2] == 3'd0) a_d[lane*DATA_W +: DATA_W] = databus_in;
         if (addr[4:2] == 3'd1) b_d[lane*DATA_W +: DATA_W] = databus_in;
      end
   end

   always_comb begin
      cmd_cnt_d = cmd_cnt_q + CCW'(cmd_push) - CCW'(cmd_pop);
      res_cnt_d = res_cnt_q + RCW'(res_push) - RCW'(res_pop);
      if (flush) begin
         cmd_cnt_d = '0;
         res_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q   <= S_IDLE;
         wr_q      <= 1'b1;
         end_ack_q <= 1'b0;
         ovf_q     <= 1'b0;
         discard_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         cmd_wp_q  <= '0;
         cmd_rp_q  <= '0;
         cmd_cnt_q <= '0;
         res_wp_q  <= '0;
         res_rp_q  <= '0;
         res_cnt_q <= '0;
         core_a_q  <= '0;
         core_b_q  <= '0;
         core_op_q <= '0;
      end else begin
         state_q   <= state_d;
         wr_q      <= wr;
         end_ack_q <= end_ack;
         ovf_q     <= ovf_d;
         discard_q <= discard_d;
         a_q       <= a_d;
         b_q       <= b_d;
         cmd_cnt_q <= cmd_cnt_d;
         res_cnt_q <= res_cnt_d;
         if (flush) begin
            cmd_rp_q <= cmd_wp_q;
            res_rp_q <= res_wp_q;
         end else begin
            if (cmd_push) cmd_wp_q <= cmd_wp_q + CAW'(1);
            if (cmd_pop)  cmd_rp_q <= cmd_rp_q + CAW'(1);
            if (res_push) res_wp_q <= res_wp_q + RAW'(1);
            if (res_pop)  res_rp_q <= res_rp_q + RAW'(1);
         end
         if (load_core) begin
            core_a_q  <= cmd_a_mem[cmd_rp_q];
            core_b_q  <= cmd_b_mem[cmd_rp_q];
            core_op_q <= cmd_op_mem[cmd_rp_q];
         end
      end
   end

   // FIFO storage carries no reset; occupancy counters define validity
   always_ff @(posedge clk) begin
      if (cmd_push) begin
         cmd_a_mem[cmd_wp_q]  <= a_q;
         cmd_b_mem[cmd_wp_q]  <= b_q;
         cmd_op_mem[cmd_wp_q] <= databus_in[OPC_W-1:0];
      end
      if (res_push) res_mem[res_wp_q] <= core_result;
   end

   assign res_sat = (32'(res_cnt_q) > 7) ? 3'd7 : 3'(res_cnt_q);
   assign status  = {res_sat, ovf_q, res_empty, cmd_empty, cmd_full, busy};

   always_comb begin
      rdata = '0;
      if (!cs && !rd && arst_n) begin
         if ((addr[4:2] == 3'd0) && lane_ok)
            rdata = a_q[lane*DATA_W +: DATA_W];
         else if ((addr[4:2] == 3'd1) && lane_ok)
            rdata = b_q[lane*DATA_W +: DATA_W];
         else if (addr == 5'h09)
            rdata = DATA_W'(status);
         else if ((addr[4:2] == 3'd3) && lane_ok && !res_empty)
            rdata = res_head[lane*DATA_W +: DATA_W];
      end
   end

   assign databus_out = rdata;
   assign cmd_end     = !res_empty && !end_ack_q;
   assign busy        = !cmd_empty || (state_q != S_IDLE);
   assign core_start  = state_q == S_ISSUE;
   assign core_a      = core_a_q;
   assign core_b      = core_b_q;
   assign core_op     = core_op_q;

endmodule

// File: tb/tb_fpu_host_if.sv
// Directed bench for fpu_host_if with a behavioural FPU core model.
module tb_fpu_host_if;
   localparam int DATA_W = 8, OP_W = 32, OPC_W = 4, CMD_DEPTH = 4, RES_DEPTH = 4;

   logic              clk = 1'b0;
   logic              arst_n = 1'b0;
   logic [DATA_W-1:0] databus_in = '0;
   logic [DATA_W-1:0] databus_out;
   logic [4:0]        addr = '0;
   logic              cs = 1'b1, rd = 1'b1, wr = 1'b1, end_ack = 1'b0;
   logic              cmd_end, busy, core_start;
   logic [OP_W-1:0]   core_a, core_b;
   logic [OPC_W-1:0]  core_op;
   logic              core_done;
   logic [OP_W-1:0]   core_result = '0;

   int n_cmp = 0, n_bad = 0;

   fpu_host_if #(.DATA_W(DATA_W), .OP_W(OP_W), .OPC_W(OPC_W),
                 .CMD_DEPTH(CMD_DEPTH), .RES_DEPTH(RES_DEPTH)) dut (
      .clk(clk), .arst_n(arst_n), .databus_in(databus_in), .databus_out(databus_out),
      .addr(addr), .cs(cs), .rd(rd), .wr(wr), .end_ack(end_ack), .cmd_end(cmd_end),
      .busy(busy), .core_a(core_a), .core_b(core_b), .core_op(core_op),
      .core_start(core_start), .core_done(core_done), .core_result(core_result)
   );

   always #5 clk = ~clk;

   // Core model: fixed latency, optional stall, and one-shot injected completions
   int          core_lat = 2;
   logic        core_hold = 1'b0;
   int          inj_cnt = 0, inj_seen = 0;
   logic [31:0] inj_val = '0;
   int          start_cnt = 0, overlap_cnt = 0;
   logic [3:0]  op_log[$];
   logic        pend_m = 1'b0;
   int          cnt_m = 0;
   logic [31:0] pres_m = '0;

   function automatic logic [31:0] core_fn(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
      if (a == 32'h3f800000 && b == 32'h3f8ccccd && op == 4'h1) return 32'h40066666;
      return a + b;
   endfunction

   always @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         core_done <= 1'b0;
         pend_m    <= 1'b0;
      end else begin
         core_done <= 1'b0;
         if (core_start) begin
            start_cnt <= start_cnt + 1;
            if (pend_m) overlap_cnt <= overlap_cnt + 1;
            op_log.push_back(core_op);
            pend_m <= 1'b1;
            cnt_m  <= core_lat;
            pres_m <= core_fn(core_a, core_b, core_op);
         end else if (pend_m && !core_hold) begin
            if (cnt_m <= 1) begin
               core_done   <= 1'b1;
               core_result <= pres_m;
               pend_m      <= 1'b0;
            end else cnt_m <= cnt_m - 1;
         end
         if (inj_cnt != inj_seen) begin
            inj_seen    <= inj_cnt;
            core_done   <= 1'b1;
            core_result <= inj_val;
            pend_m      <= 1'b0;
         end
      end
   end

   task automatic host_wr(input logic [4:0] a, input logic [7:0] d);
      @(negedge clk); addr = a; databus_in = d; cs = 1'b0; wr = 1'b0;
      @(negedge clk); wr = 1'b1; cs = 1'b1;
   endtask

   task automatic host_rd(input logic [4:0] a, output logic [7:0] d);
      @(negedge clk); addr = a; cs = 1'b0; rd = 1'b0;
      #1 d = databus_out;
      cs = 1'b1; rd = 1'b1;
   endtask

   task automatic read_res(output logic [31:0] r);
      logic [7:0] v;
      for (int i = 0; i < 4; i++) begin
         host_rd(5'h0C + 5'(i), v);
         r[i*8 +: 8] = v;
      end
   endtask

   task automatic wait_cmd_end(output logic ok);
      int t;
      t = 0;
      while (cmd_end !== 1'b1 && t < 100) begin @(negedge clk); t++; end
      ok = (cmd_end === 1'b1);
   endtask

   task automatic test_reset();
      logic [7:0] rv;
      repeat (2) @(negedge clk);
      n_cmp++; if ({cmd_end, busy, core_start} !== 3'b000) begin n_bad++; $display("FAIL reset_ctl: got %b want 000", {cmd_end, busy, core_start}); end
      n_cmp++; if (core_a !== 32'h0) begin n_bad++; $display("FAIL reset_core_a: got %h want 0", core_a); end
      arst_n = 1'b1;
      host_rd(5'h09, rv);
      n_cmp++; if (rv !== 8'h0C) begin n_bad++; $display("FAIL reset_status: got %h want 0c", rv); end
   endtask

   task automatic test_basic();
      logic [7:0]  rv;
      logic [31:0] r;
      logic        ok;
      core_lat = 2;
      host_wr(5'h00, 8'h00); host_wr(5'h01, 8'h00); host_wr(5'h02, 8'h80); host_wr(5'h03, 8'h3f);
      host_wr(5'h04, 8'hcd); host_wr(5'h05, 8'hcc); host_wr(5'h06, 8'h8c); host_wr(5'h07, 8'h3f);
      host_rd(5'h02, rv);
      n_cmp++; if (rv !== 8'h80) begin n_bad++; $display("FAIL stage_a_lane2: got %h want 80", rv); end
      host_rd(5'h05, rv);
      n_cmp++; if (rv !== 8'hcc) begin n_bad++; $display("FAIL stage_b_lane1: got %h want cc", rv); end
      host_wr(5'h08, 8'h01);
      #1;
      n_cmp++; if (core_start !== 1'b0) begin n_bad++; $display("FAIL start_early: got %b want 0", core_start); end
      @(negedge clk); #1;
      n_cmp++; if (core_start !== 1'b1) begin n_bad++; $display("FAIL start_latency: got %b want 1", core_start); end
      n_cmp++; if ({core_a, core_b, core_op} !== {32'h3f800000, 32'h3f8ccccd, 4'h1}) begin n_bad++; $display("FAIL issue_operands: got %h %h %h want 3f800000 3f8ccccd 1", core_a, core_b, core_op); end
      @(negedge clk); #1;
      n_cmp++; if ({core_start, busy} !== 2'b01) begin n_bad++; $display("FAIL start_pulse_busy: got %b want 01", {core_start, busy}); end
      wait_cmd_end(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_cmd_end: got timeout want 1"); end
      read_res(r);
      n_cmp++; if (r !== 32'h40066666) begin n_bad++; $display("FAIL basic_result: got %h want 40066666", r); end
      host_rd(5'h09, rv);
      n_cmp++; if (rv !== 8'h24) begin n_bad++; $display("FAIL basic_status: got %h want 24", rv); end
      @(negedge clk); end_ack = 1'b1;
      @(negedge clk); #1;
      n_cmp++; if (cmd_end !== 1'b0) begin n_bad++; $display("FAIL basic_ack_drop: got %b want 0", cmd_end); end
      end_ack = 1'b0;
      @(negedge clk);
      host_rd(5'h09, rv);
      n_cmp++; if (rv !== 8'h0C || cmd_end !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL basic_after_ack: got %h %b %b want 0c 0 0", rv, cmd_end, busy); end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  rv;
      logic [31:0] r;
      logic        ok;
      int          s0;
      core_lat = 20;
      s0 = start_cnt;
      op_log.delete();
      for (int k = 1; k <= 4; k++) begin
         host_wr(5'h04, 8'(k));
         host_wr(5'h08, 8'(k));
      end
      repeat (150) @(negedge clk);
      n_cmp++; if (start_cnt - s0 !== 4 || overlap_cnt !== 0) begin n_bad++; $display("FAIL b2b_issue: got starts %0d overlaps %0d want 4 0", start_cnt - s0, overlap_cnt); end
      n_cmp++; if (op_log.size() !== 4) begin n_bad++; $display("FAIL b2b_oplog_size: got %0d want 4", op_log.size()); end
      else for (int k = 0; k < 4; k++) begin
         n_cmp++; if (op_log[k] !== 4'(k + 1)) begin n_bad++; $display("FAIL b2b_op_order: got %h want %h", op_log[k], 4'(k + 1)); end
      end
      host_rd(5'h09, rv);
      n_cmp++; if (rv !== 8'h84) begin n_bad++; $display("FAIL b2b_status: got %h want 84", rv); end
      for (int k = 1; k <= 4; k++) begin
         wait_cmd_end(ok);
         n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_cmd_end: got timeout want 1"); end
         read_res(r);
         n_cmp++; if (r !== 32'h7F0CCC00 + 32'(k)) begin n_bad++; $display("FAIL b2b_result: got %h want %h", r, 32'h7F0CCC00 + 32'(k)); end
         @(negedge clk); end_ack = 1'b1;
         @(negedge clk); #1;
         n_cmp++; if (cmd_end !== 1'b0) begin n_bad++; $display("FAIL b2b_ack_drop: got %b want 0", cmd_end); end
         end_ack = 1'b0;
         @(negedge clk); #1;
         n_cmp++; if (cmd_end !== (k < 4)) begin n_bad++; $display("FAIL b2b_rerise: got %b want %b", cmd_end, (k < 4)); end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] rv;
      int         s0;
      core_lat  = 2;
      core_hold = 1'b1;
      s0 = start_cnt;
      for (int k = 0; k < 6; k++) host_wr(5'h08, 8'h05);
      repeat (2) @(negedge clk);
      n_cmp++; if (start_cnt - s0 !== 1) begin n_bad++; $display("FAIL ovf_starts: got %0d want 1", start_cnt - s0); end
      host_rd(5'h09, rv);
      n_cmp++; if (rv !== 8'h1B) begin n_bad++; $display("FAIL ovf_status: got %h want 1b", rv); end
      host_wr(5'h09, 8'h01);
      host_rd(5'h09, rv);
      n_cmp++; if (rv !== 8'h1C) begin n_bad++; $display("FAIL ovf_flush_keeps_ovf: got %h want 1c", rv); end
      host_wr(5'h09, 8'h02);
      host_rd(5'h09, rv);
      n_cmp++; if (rv !== 8'h0C) begin n_bad++; $display("FAIL ovf_clear: got %h want 0c", rv); end
      core_hold = 1'b0;
      repeat (10) @(negedge clk);
      host_rd(5'h09, rv);
      n_cmp++; if (rv !== 8'h0C || cmd_end !== 1'b0 || start_cnt - s0 !== 1) begin n_bad++; $display("FAIL ovf_discard: got %h %b %0d want 0c 0 1", rv, cmd_end, start_cnt - s0); end
   endtask

   task automatic test_no_ack_stall();
      logic [7:0] rv;
      int         s0;
      core_lat  = 2;
      core_hold = 1'b0;
      s0 = start_cnt;
      for (int k = 0; k < 3; k++) host_wr(5'h08, 8'h03);
      repeat (40) @(negedge clk);
      for (int k = 0; k < 3; k++) host_wr(5'h08, 8'h03);
      repeat (40) @(negedge clk);
      n_cmp++; if (start_cnt - s0 !== 4) begin n_bad++; $display("FAIL stall_starts: got %0d want 4", start_cnt - s0); end
      host_rd(5'h09, rv);
      n_cmp++; if (rv !== 8'h81) begin n_bad++; $display("FAIL stall_status: got %h want 81", rv); end
      @(negedge clk); end_ack = 1'b1;
      @(negedge clk); end_ack = 1'b0;
      repeat (20) @(negedge clk);
      n_cmp++; if (start_cnt - s0 !== 5) begin n_bad++; $display("FAIL stall_resume: got %0d want 5", start_cnt - s0); end
      host_wr(5'h09, 8'h01);
      host_rd(5'h09, rv);
      n_cmp++; if (rv !== 8'h0C || cmd_end !== 1'b0) begin n_bad++; $display("FAIL stall_flush: got %h %b want 0c 0", rv, cmd_end); end
   endtask

   task automatic test_flush();
      logic [7:0]  rv;
      logic [31:0] r;
      logic        ok;
      core_hold = 1'b1;
      host_wr(5'h08, 8'h07);
      repeat (4) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL flush_pre_busy: got %b want 1", busy); end
      host_wr(5'h09, 8'h01);
      #1;
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b want 0", busy); end
      inj_val = 32'hDEADBEEF;
      inj_cnt = inj_cnt + 1;
      repeat (4) @(negedge clk);
      host_rd(5'h09, rv);
      n_cmp++; if (rv !== 8'h0C || cmd_end !== 1'b0) begin n_bad++; $display("FAIL flush_discard: got %h %b want 0c 0", rv, cmd_end); end
      core_hold = 1'b0;
      host_wr(5'h08, 8'h02);
      wait_cmd_end(ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL flush_recover: got timeout want 1"); end
      read_res(r);
      n_cmp++; if (r !== 32'h7F0CCC04) begin n_bad++; $display("FAIL flush_next_result: got %h want 7f0ccc04", r); end
      @(negedge clk); end_ack = 1'b1;
      @(negedge clk); end_ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_wr_hold();
      logic [7:0] rv;
      int         s0;
      core_hold = 1'b1;
      s0 = start_cnt;
      @(negedge clk); addr = 5'h08; databus_in = 8'h03; cs = 1'b0; wr = 1'b0;
      repeat (3) @(negedge clk);
      wr = 1'b1; cs = 1'b1;
      repeat (3) @(negedge clk);
      host_rd(5'h09, rv);
      n_cmp++; if (rv !== 8'h0D || start_cnt - s0 !== 1) begin n_bad++; $display("FAIL wr_hold_once: got %h %0d want 0d 1", rv, start_cnt - s0); end
      host_rd(5'h0A, rv);
      n_cmp++; if (rv !== 8'h00) begin n_bad++; $display("FAIL unmapped_read: got %h want 00", rv); end
      host_wr(5'h09, 8'h01);
      core_hold = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic test_reset_async();
      logic [7:0] rv;
      logic       ok;
      core_hold = 1'b0;
      host_wr(5'h08, 8'h02);
      wait_cmd_end(ok);
      core_hold = 1'b1;
      host_wr(5'h08, 8'h09);
      repeat (4) @(negedge clk);
      n_cmp++; if ({ok, cmd_end, busy, core_op} !== {3'b111, 4'h9}) begin n_bad++; $display("FAIL arst_pre: got %b %b %b %h want 1 1 1 9", ok, cmd_end, busy, core_op); end
      @(negedge clk); addr = 5'h09; cs = 1'b0; rd = 1'b0;
      #2 arst_n = 1'b0;
      #1;
      n_cmp++; if ({core_a, core_b, core_op} !== '0) begin n_bad++; $display("FAIL arst_core_bus: got %h %h %h want 0 0 0", core_a, core_b, core_op); end
      n_cmp++; if ({core_start, cmd_end, busy, databus_out} !== '0) begin n_bad++; $display("FAIL arst_outputs: got %b %b %b %h want 0 0 0 00", core_start, cmd_end, busy, databus_out); end
      @(negedge clk); arst_n = 1'b1; cs = 1'b1; rd = 1'b1;
      core_hold = 1'b0;
      host_rd(5'h09, rv);
      n_cmp++; if (rv !== 8'h0C) begin n_bad++; $display("FAIL arst_status: got %h want 0c", rv); end
      host_rd(5'h03, rv);
      n_cmp++; if (rv !== 8'h00) begin n_bad++; $display("FAIL arst_staging: got %h want 00", rv); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_overflow();
      test_no_ack_stall();
      test_flush();
      test_wr_hold();
      test_reset_async();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
